// File: rtl/gb_cpu_common_pkg.sv
// Shared types and constants for the gb_cpu fetch/decode front end:
// fetch FSM states, instruction length type and the hard-lock opcode list.
package gb_cpu_common_pkg;

  typedef enum logic [2:0] {
    F0   = 3'd0,
    F1   = 3'd1,
    F2   = 3'd2,
    HOLD = 3'd3,
    LOCK = 3'd4
  } fetch_state_e;

  typedef logic [1:0] instr_len_t;

  localparam logic [7:0] OP_PREFIX_CB = 8'hCB;

  localparam int unsigned NUM_HARD_LOCK = 11;
  localparam logic [8*NUM_HARD_LOCK-1:0] HARD_LOCK_OPS = {
    8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
    8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD
  };

  function automatic logic is_hard_lock(input logic [7:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_HARD_LOCK; i++) begin
      if (HARD_LOCK_OPS[i*8 +: 8] == op) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/gb_cpu_instr_len.sv
// Combinational instruction sizer: byte0 -> length (1..3) and, when
// GB_CPU_FETCH_LOCK_EN is defined, the hard-lock opcode flag.
module gb_cpu_instr_len
  import gb_cpu_common_pkg::*;
(
  input  logic [7:0] byte0,
  output instr_len_t len
`ifdef GB_CPU_FETCH_LOCK_EN
  ,
  output logic       hard_lock
`endif
);

  // Opcode-class decode; masks pick out the register-field wildcards.
  always_comb begin
    if (((byte0 & 8'hCF) == 8'h01) || (byte0 == 8'h08) ||
        ((byte0 & 8'hE7) == 8'hC2) || (byte0 == 8'hC3) ||
        ((byte0 & 8'hE7) == 8'hC4) || (byte0 == 8'hCD) ||
        (byte0 == 8'hEA) || (byte0 == 8'hFA)) begin
      len = 2'd3;
    end else if (((byte0 & 8'hC7) == 8'h06) || (byte0 == 8'h10) ||
                 (byte0 == 8'h18) || ((byte0 & 8'hE7) == 8'h20) ||
                 ((byte0 & 8'hC7) == 8'hC6) || (byte0 == 8'hE0) ||
                 (byte0 == 8'hF0) || (byte0 == 8'hE8) ||
                 (byte0 == 8'hF8) || (byte0 == OP_PREFIX_CB)) begin
      len = 2'd2;
    end else begin
      len = 2'd1;
    end
  end

`ifdef GB_CPU_FETCH_LOCK_EN
  assign hard_lock = is_hard_lock(byte0);
`endif

endmodule

// File: rtl/gb_cpu_fetch.sv
// Instruction fetch/assembly stage feeding gb_cpu_decoder. Optional hard-lock
// behaviour on illegal opcodes is built when GB_CPU_FETCH_LOCK_EN is defined.
module gb_cpu_fetch
  import gb_cpu_common_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_rd_req,
  output logic [15:0] mem_addr,
  input  logic        mem_rd_ack,
  input  logic [7:0]  mem_rd_data,
  input  logic        redirect_vld,
  input  logic [15:0] redirect_pc,
  output logic        instr_vld,
  input  logic        instr_rdy,
  output logic [23:0] instr,
  output logic [1:0]  instr_len,
  output logic [15:0] instr_pc,
  output logic        locked
);

  fetch_state_e state_r, state_n;
  logic [15:0]  pc_r, pc_n, addr_r, addr_n, ipc_r, ipc_n;
  logic         flush_r, flush_n, req_r, req_n, vld_r, vld_n;
  logic [23:0]  instr_r, instr_n;
  instr_len_t   len_r, len_n, len_s;
  logic         ack_s;
  logic [15:0]  pc_inc_s;

  assign ack_s    = mem_rd_ack & req_r;
  assign pc_inc_s = pc_r + 16'd1;

`ifdef GB_CPU_FETCH_LOCK_EN
  logic hard_lock_s, pend_r, pend_n, lock_r;

  gb_cpu_instr_len u_len (
    .byte0     (mem_rd_data),
    .len       (len_s),
    .hard_lock (hard_lock_s)
  );
`else
  gb_cpu_instr_len u_len (
    .byte0 (mem_rd_data),
    .len   (len_s)
  );
`endif

  // Next-state, fetch request and instruction assembly.
  always_comb begin
    state_n = state_r;
    pc_n    = pc_r;
    addr_n  = addr_r;
    flush_n = flush_r;
    req_n   = req_r;
    vld_n   = vld_r;
    instr_n = instr_r;
    len_n   = len_r;
    ipc_n   = ipc_r;
`ifdef GB_CPU_FETCH_LOCK_EN
    pend_n  = pend_r;
    if (state_r == LOCK) begin
      req_n = 1'b0;
      vld_n = 1'b0;
    end else
`endif
    if (redirect_vld) begin
      state_n = F0;
      pc_n    = redirect_pc;
      vld_n   = 1'b0;
      // An in-flight read must finish at its old address; its data is dropped.
      if (req_r && !mem_rd_ack) begin
        flush_n = 1'b1;
      end else begin
        flush_n = 1'b0;
        req_n   = 1'b1;
        addr_n  = redirect_pc;
      end
    end else if (flush_r) begin
      if (ack_s) begin
        flush_n = 1'b0;
        addr_n  = pc_r;
      end else begin
        flush_n = 1'b1;
      end
    end else begin
      case (state_r)
        F0: begin
          if (ack_s) begin
            instr_n = {mem_rd_data, 16'h0000};
            len_n   = len_s;
            ipc_n   = addr_r;
            pc_n    = pc_inc_s;
`ifdef GB_CPU_FETCH_LOCK_EN
            pend_n  = hard_lock_s;
`endif
            if (len_s == 2'd1) begin
              state_n = HOLD;
              req_n   = 1'b0;
              vld_n   = 1'b1;
            end else begin
              state_n = F1;
              addr_n  = pc_inc_s;
            end
          end else begin
            req_n  = 1'b1;
            addr_n = pc_r;
          end
        end
        F1: begin
          if (ack_s) begin
            instr_n[15:8] = mem_rd_data;
            pc_n          = pc_inc_s;
            if (len_r == 2'd2) begin
              state_n = HOLD;
              req_n   = 1'b0;
              vld_n   = 1'b1;
            end else begin
              state_n = F2;
              addr_n  = pc_inc_s;
            end
          end else begin
            req_n = 1'b1;
          end
        end
        F2: begin
          if (ack_s) begin
            instr_n[7:0] = mem_rd_data;
            pc_n         = pc_inc_s;
            state_n      = HOLD;
            req_n        = 1'b0;
            vld_n        = 1'b1;
          end else begin
            req_n = 1'b1;
          end
        end
        HOLD: begin
          if (instr_rdy) begin
            vld_n = 1'b0;
`ifdef GB_CPU_FETCH_LOCK_EN
            if (pend_r) begin
              state_n = LOCK;
              req_n   = 1'b0;
            end else begin
              state_n = F0;
              req_n   = 1'b1;
              addr_n  = pc_r;
            end
`else
            state_n = F0;
            req_n   = 1'b1;
            addr_n  = pc_r;
`endif
          end else begin
            vld_n = 1'b1;
          end
        end
        default: begin
          state_n = F0;
          req_n   = 1'b0;
          vld_n   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= F0;
      pc_r    <= RESET_PC;
      addr_r  <= RESET_PC;
      flush_r <= 1'b0;
      req_r   <= 1'b0;
      vld_r   <= 1'b0;
      instr_r <= 24'h000000;
      len_r   <= 2'd1;
      ipc_r   <= 16'h0000;
    end else begin
      state_r <= state_n;
      pc_r    <= pc_n;
      addr_r  <= addr_n;
      flush_r <= flush_n;
      req_r   <= req_n;
      vld_r   <= vld_n;
      instr_r <= instr_n;
      len_r   <= len_n;
      ipc_r   <= ipc_n;
    end
  end

`ifdef GB_CPU_FETCH_LOCK_EN
  // Hard-lock bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= 1'b0;
      lock_r <= 1'b0;
    end else begin
      pend_r <= pend_n;
      lock_r <= (state_n == LOCK);
    end
  end

  assign locked = lock_r;
`else
  assign locked = 1'b0;
`endif

  assign mem_rd_req = req_r;
  assign mem_addr   = addr_r;
  assign instr_vld  = vld_r;
  assign instr      = instr_r;
  assign instr_len  = len_r;
  assign instr_pc   = ipc_r;

endmodule
